// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with 2-entry {pc, instr} output FIFO
//
// Purpose: fetches one instruction word per cycle from a combinational
// instruction memory and buffers up to two {pc, instr} pairs for decode.
// A redirect flushes the buffer and restarts fetch at the target address.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   reset        in   asynchronous active-high reset
//   instr_addr   out  fetch byte address (the fetch PC)
//   instr        in   instruction word for instr_addr, same cycle
//   redirect     in   branch/jump redirect strobe
//   redirect_pc  in   redirect target byte address
//   out_valid    out  head entry valid
//   out_ready    in   decode accepts the head entry this cycle
//   out_instr    out  head instruction word
//   out_pc       out  byte address of out_instr
//   misalign_err out  sticky misaligned-redirect flag (only with
//                     INSTR_FETCH_MISALIGN_CHECK_EN defined)
//
// Configuration macro: INSTR_FETCH_MISALIGN_CHECK_EN

module instr_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_err
`endif
);

    logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] fifo_pc_q    [2];
    logic [DATA_WIDTH-1:0] fifo_instr_q [2];

    logic pop;
    logic capture;
    logic halt;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    logic misalign_err_q, misalign_err_d;
    assign misalign_err = misalign_err_q;
    // A misaligned redirect freezes fetch until an aligned redirect or reset.
    assign halt = misalign_err_q;
`else
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];
    assign halt = 1'b0;
`endif

    assign instr_addr = fpc_q;
    assign out_valid  = (count_q != 2'd0);
    assign out_instr  = fifo_instr_q[rd_ptr_q];
    assign out_pc     = fifo_pc_q[rd_ptr_q];

    // Redirect wins over both pop and capture in the same cycle.
    assign pop     = out_valid & out_ready & ~redirect;
    // A pop frees a slot this cycle, so a full FIFO can still capture.
    assign capture = ~redirect & ~halt & ((count_q != 2'd2) | pop);

    always_comb begin
        fpc_d    = fpc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        misalign_err_d = misalign_err_q;
`endif
        if (redirect) begin
            fpc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
            misalign_err_d = |redirect_pc[1:0];
`endif
        end else begin
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (capture) begin
                wr_ptr_d = ~wr_ptr_q;
                // Wraps modulo 2^ADDR_WIDTH by construction.
                fpc_d    = fpc_q + ADDR_WIDTH'(4);
            end
            count_d = count_q + {1'b0, capture} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q           <= RESET_PC;
            count_q         <= 2'd0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            fifo_pc_q[0]    <= '0;
            fifo_pc_q[1]    <= '0;
            fifo_instr_q[0] <= '0;
            fifo_instr_q[1] <= '0;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
            misalign_err_q  <= 1'b0;
`endif
        end else begin
            fpc_q    <= fpc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (capture) begin
                fifo_pc_q[wr_ptr_q]    <= fpc_q;
                fifo_instr_q[wr_ptr_q] <= instr;
            end
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
            misalign_err_q <= misalign_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with queue reference model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction memory: word[i] = i.
    assign instr = instr_addr >> 2;

    instr_fetch #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_addr (instr_addr),
        .instr      (instr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pending PCs held in a queue, fetch PC as a plain number.
    logic [31:0] m_q[$];
    logic [31:0] m_fpc = 32'h0;
    logic        m_err = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_fpc = 32'h0;
            m_err = 1'b0;
        end else if (redirect) begin
            m_q.delete();
            m_fpc = redirect_pc & 32'hFFFF_FFFC;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
            m_err = (redirect_pc[1:0] != 2'b00);
`endif
        end else begin
            bit do_pop;
            bit do_cap;
            do_pop = (m_q.size() > 0) && out_ready;
            do_cap = ((m_q.size() < 2) || do_pop) && !m_err;
            if (do_pop) void'(m_q.pop_front());
            if (do_cap) begin
                m_q.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_instr_addr", instr_addr, m_fpc);
        chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0 && out_valid) begin
            chk("cyc_out_pc", out_pc, m_q[0]);
            chk("cyc_out_instr", out_instr, m_q[0] >> 2);
        end
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        chk("cyc_misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] lo;

        // Reset state and release with out_ready=1.
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_instr_addr", instr_addr, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("rel_pc0", out_pc, 32'h0);
        chk("rel_instr0", out_instr, 32'h0);
        tick();
        chk("rel_pc1", out_pc, 32'h4);
        chk("rel_instr1", out_instr, 32'h1);
        tick();
        chk("rel_pc2", out_pc, 32'h8);
        chk("rel_instr2", out_instr, 32'h2);

        // Back-pressure from reset: FIFO fills, fetch stalls at 8.
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("stall_valid", {31'b0, out_valid}, 32'h1);
        chk("stall_addr", instr_addr, 32'h8);
        chk("stall_head", out_pc, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("stall_pop_next", out_pc, 32'h4);
        chk("full_addr", instr_addr, 32'hC);

        // Redirect while full.
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("redir_valid", {31'b0, out_valid}, 32'h0);
        chk("redir_addr", instr_addr, 32'h40);
        tick();
        chk("redir_pc", out_pc, 32'h40);

        // Address wrap.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        chk("wrap_pc_hi", out_pc, 32'hFFFF_FFFC);
        chk("wrap_instr_hi", out_instr, 32'h3FFF_FFFF);
        tick();
        chk("wrap_pc_lo", out_pc, 32'h0);

        // Misaligned redirect.
        redirect = 1'b1;
        redirect_pc = 32'h42;
        tick();
        redirect = 1'b0;
        chk("mis_addr", instr_addr, 32'h40);
        tick();
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        chk("mis_err", {31'b0, misalign_err}, 32'h1);
        chk("mis_valid", {31'b0, out_valid}, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        chk("mis_clear", {31'b0, misalign_err}, 32'h0);
        tick();
        chk("mis_resume_pc", out_pc, 32'h80);
`else
        chk("mis_resume_pc", out_pc, 32'h40);
`endif

        // Reset between clock edges takes effect immediately.
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", {31'b0, out_valid}, 32'h0);
        chk("async_addr", instr_addr, 32'h0);
        tick();
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 19) == 0);
            r = $urandom;
            lo = $urandom;
            if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0;
            r[1:0] = ($urandom_range(0, 3) == 0) ? lo[1:0] : 2'b00;
            redirect_pc = r;
        end
        tick();
        reset = 1'b0;
        redirect = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
